// File: rtl/fft_spi_pkg.sv
// Shared defaults, FSM state type and counter sizing for the FFT-link SPI master.
package fft_spi_pkg;

  localparam int unsigned DEFAULT_FRAME_BITS = 1024;
  localparam int unsigned DEFAULT_CLK_DIV    = 4;
  localparam int unsigned DEFAULT_CNT_W      = $clog2(DEFAULT_FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD
  } spi_state_e;

endpackage

// File: rtl/fft_spi_master_timer.sv
// Half-period timer: reloads to CLK_DIV-1 on load, counts down, ticks while at zero.
module spi_half_period_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick
);

  localparam int unsigned    W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0]   RELOAD = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/fft_spi_master.sv
// Mode-0 SPI master: full-duplex FRAME_BITS frame, MSB first, sck half-period CLK_DIV clocks.
// Define FFT_SPI_MASTER_LOOPBACK_EN to capture the internal sdo instead of the sdi pin.
module fft_spi_master
  import fft_spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS = DEFAULT_FRAME_BITS,
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_frame,
  input  logic                  sdi,
  output logic                  sck,
  output logic                  cs,
  output logic                  sdo,
  output logic [FRAME_BITS-1:0] rx_frame,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned      CNT_W    = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  spi_state_e state_q, state_d;

  logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [FRAME_BITS-1:0] rx_frame_q, rx_frame_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sck_q, sck_d;
  logic                  cs_q, cs_d;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic tick;
  logic tmr_load;
  logic rx_bit;

`ifdef FFT_SPI_MASTER_LOOPBACK_EN
  logic sdi_unused;
  assign sdi_unused = sdi;
  assign rx_bit     = sdo_q;
`else
  assign rx_bit = sdi;
`endif

  // Held in reload while idle so every timed state starts a fresh CLK_DIV window.
  assign tmr_load = (state_q == IDLE) || tick;

  spi_half_period_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (tmr_load),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_frame_q <= '0;
      cnt_q      <= '0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_frame_q <= rx_frame_d;
      cnt_q      <= cnt_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      sdo_q      <= sdo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (tick)  state_d = HIGH;
      HIGH:    if (tick)  state_d = (cnt_q == LAST_BIT) ? HOLD : LOW;
      LOW:     if (tick)  state_d = HIGH;
      HOLD:    if (tick)  state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_frame_d = rx_frame_q;
    cnt_d      = cnt_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    sdo_d      = sdo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_sr_d = tx_frame;
          rx_sr_d = '0;
          cnt_d   = '0;
          cs_d    = 1'b0;
          sdo_d   = tx_frame[FRAME_BITS-1];
          busy_d  = 1'b1;
        end
      end
      // Capture happens on the same clock that raises sck (the mode-0 sampling edge).
      SETUP, LOW: begin
        if (tick) begin
          sck_d   = 1'b1;
          rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], rx_bit};
        end
      end
      HIGH: begin
        if (tick) begin
          sck_d = 1'b0;
          if (cnt_q != LAST_BIT) begin
            cnt_d   = cnt_q + CNT_W'(1);
            tx_sr_d = tx_sr_q << 1;
            sdo_d   = tx_sr_q[FRAME_BITS-2];
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_d       = 1'b1;
          sdo_d      = 1'b0;
          busy_d     = 1'b0;
          rx_frame_d = rx_sr_q;
          done_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign sck      = sck_q;
  assign cs       = cs_q;
  assign sdo      = sdo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_frame = rx_frame_q;

endmodule
